// File: rtl/result_writeback_if.sv
// Result stream plus SRAM write request bus.
// The master modport is the writeback engine: it sinks the accumulator stream and sources
// SRAM write requests. The slave modport is the surrounding environment.
interface result_writeback_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  in_vld;
  logic                  in_rdy;
  logic [ACC_WIDTH-1:0]  in_data;
  logic                  w_req_vld;
  logic                  w_req_rdy;
  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic [DATA_WIDTH-1:0] w_req_data;

  modport master (
    input  in_vld, in_data, w_req_rdy,
    output in_rdy, w_req_vld, w_req_addr, w_req_data
  );

  modport slave (
    output in_vld, in_data, w_req_rdy,
    input  in_rdy, w_req_vld, w_req_addr, w_req_data
  );
endinterface

// File: rtl/result_writeback.sv
// Result writeback: requantizes MAT_DIM accumulators of one output vector to unsigned
// DATA_WIDTH values (round half up, shift, saturate) and writes them to SRAM at
// consecutive addresses starting from a programmed base.
module result_writeback #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MAT_DIM    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op_code,
  input  logic [ADDR_WIDTH-1:0] cfg_data,
  result_writeback_if.master    bus,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CntW = $clog2(MAT_DIM + 1);
  localparam int unsigned SumW = ACC_WIDTH + 1;

  localparam logic [1:0] OpSetBase  = 2'b00;
  localparam logic [1:0] OpSetShift = 2'b01;
  localparam logic [1:0] OpArm      = 2'b10;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] y_base_q, y_base_d;
  logic [4:0]            shift_q, shift_d;
  logic [CntW-1:0]       in_cnt_q, in_cnt_d;
  logic [CntW-1:0]       out_cnt_q, out_cnt_d;
  logic                  w_vld_q, w_vld_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;

  logic                  in_hs;
  logic                  w_hs;
  logic [SumW-1:0]       round_val;
  logic [SumW-1:0]       sum_val;
  logic [SumW-1:0]       shifted;
  logic [DATA_WIDTH-1:0] q_val;

  // Requantize the incoming accumulator; the extra sum bit keeps all-ones inputs from wrapping.
  always_comb begin
    round_val = '0;
    if (shift_q != 5'd0) begin
      round_val = SumW'(1) << (shift_q - 5'd1);
    end
    sum_val = {1'b0, bus.in_data} + round_val;
    shifted = sum_val >> shift_q;
    if ((shifted >> DATA_WIDTH) != '0) begin
      q_val = '1;
    end else begin
      q_val = shifted[DATA_WIDTH-1:0];
    end
  end

  // Stream handshakes and status outputs.
  always_comb begin
    bus.in_rdy     = (state_q == StRun) && (in_cnt_q < CntW'(MAT_DIM)) &&
                     (!w_vld_q || bus.w_req_rdy);
    in_hs          = bus.in_vld && bus.in_rdy;
    w_hs           = w_vld_q && bus.w_req_rdy;
    bus.w_req_vld  = w_vld_q;
    bus.w_req_addr = w_addr_q;
    bus.w_req_data = w_data_q;
    busy           = (state_q == StRun);
    done           = (state_q == StDone);
  end

  // Next-state logic: configuration in idle, element transfer in run.
  always_comb begin
    state_d   = state_q;
    y_base_d  = y_base_q;
    shift_d   = shift_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    w_vld_d   = w_vld_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          case (op_code)
            OpSetBase:  y_base_d = cfg_data;
            OpSetShift: shift_d  = cfg_data[4:0];
            OpArm: begin
              in_cnt_d  = '0;
              out_cnt_d = '0;
              state_d   = StRun;
            end
            default: ;
          endcase
        end
      end
      StRun: begin
        if (w_hs) begin
          w_vld_d   = 1'b0;
          out_cnt_d = out_cnt_q + CntW'(1);
        end
        // A new accept reloads the output register in the same cycle as a write accept.
        if (in_hs) begin
          w_vld_d  = 1'b1;
          w_addr_d = y_base_q + ADDR_WIDTH'(in_cnt_q);
          w_data_d = q_val;
          in_cnt_d = in_cnt_q + CntW'(1);
        end
        if (out_cnt_d == CntW'(MAT_DIM)) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      y_base_q  <= '0;
      shift_q   <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      w_vld_q   <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      y_base_q  <= y_base_d;
      shift_q   <= shift_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      w_vld_q   <= w_vld_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
    end
  end

endmodule

// File: tb/tb_result_writeback.sv
// Directed, table-driven bench for result_writeback.
module tb_result_writeback;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] op_code;
  logic [7:0] cfg_data;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  result_writeback_if #(.DATA_WIDTH(8), .ACC_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  result_writeback #(
    .DATA_WIDTH(8),
    .ACC_WIDTH (32),
    .ADDR_WIDTH(8),
    .MAT_DIM   (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_code (op_code),
    .cfg_data(cfg_data),
    .bus     (bus),
    .busy    (busy),
    .done    (done)
  );

  typedef struct packed {
    logic [7:0]       base;
    logic [4:0]       shift;
    logic [3:0][31:0] acc;
    logic [3:0][7:0]  ea;
    logic [3:0][7:0]  ed;
    logic [31:0]      stall;   // bit c set: w_req_rdy low in stream cycle c
    logic             mid_cfg; // issue SET_Y_BASE 0x10 while running
    logic             timing;  // check latency and back-to-back writes
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;

  int         cyc = 0;
  int         acc_cnt = 0;
  int         acc_base = 0;
  int         done_cnt = 0;
  int         first_acc_cyc = -1;
  logic [7:0] wq_addr[$];
  logic [7:0] wq_data[$];
  int         wq_cyc[$];
  logic       prev_stall = 1'b0;
  logic       prev_busy = 1'b0;
  logic [7:0] prev_addr = '0;
  logic [7:0] prev_data = '0;

  vec_t tbl[5];
  vec_t vrst;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Negedge monitor: records handshakes and checks stall/done invariants.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_vld", bus.w_req_vld, 1);
        check("stall_hold_addr", bus.w_req_addr, prev_addr);
        check("stall_hold_data", bus.w_req_data, prev_data);
      end
      if (bus.w_req_vld && !bus.w_req_rdy) check("stall_in_rdy", bus.in_rdy, 0);
      if (bus.w_req_vld && bus.w_req_rdy) begin
        wq_addr.push_back(bus.w_req_addr);
        wq_data.push_back(bus.w_req_data);
        wq_cyc.push_back(cyc);
      end
      if (bus.in_vld && bus.in_rdy) begin
        acc_cnt++;
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        check("busy_falls_with_done", {prev_busy, busy}, 2'b10);
      end
      prev_stall = bus.w_req_vld && !bus.w_req_rdy;
      prev_addr  = bus.w_req_addr;
      prev_data  = bus.w_req_data;
      prev_busy  = busy;
    end
  end

  task automatic cfg(input logic [1:0] op, input logic [7:0] data);
    start    = 1'b1;
    op_code  = op;
    cfg_data = data;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    done_cnt      = 0;
    first_acc_cyc = -1;
    acc_base      = acc_cnt;
  endtask

  task automatic run_vec(input string nm, input bit do_cfg, input vec_t v);
    int k;
    bit finished;
    if (do_cfg) begin
      cfg(2'b00, v.base);
      cfg(2'b01, {3'b000, v.shift});
    end
    clear_log();
    cfg(2'b10, 8'h00);
    finished = 1'b0;
    for (int c = 0; c < 80 && !finished; c++) begin
      k = acc_cnt - acc_base;
      bus.in_vld    = (k < 4);
      bus.in_data   = (k < 4) ? v.acc[k] : 32'h0;
      bus.w_req_rdy = (c < 32) ? !v.stall[c] : 1'b1;
      if (v.mid_cfg && c == 1) begin
        start    = 1'b1;
        op_code  = 2'b00;
        cfg_data = 8'h10;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done_cnt != 0) finished = 1'b1;
    end
    start         = 1'b0;
    bus.in_vld    = 1'b0;
    bus.w_req_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check({nm, "_done_once"}, done_cnt, 1);
    check({nm, "_write_count"}, wq_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wq_addr.size()) begin
        check($sformatf("%s_addr%0d", nm, i), wq_addr[i], v.ea[i]);
        check($sformatf("%s_data%0d", nm, i), wq_data[i], v.ed[i]);
      end
    end
    if (v.timing && wq_cyc.size() == 4) begin
      check({nm, "_first_latency"}, wq_cyc[0] - first_acc_cyc, 1);
      for (int i = 1; i < 4; i++) begin
        check($sformatf("%s_gap%0d", nm, i), wq_cyc[i] - wq_cyc[i-1], 1);
      end
    end
  endtask

  initial begin
    start         = 1'b0;
    op_code       = 2'b00;
    cfg_data      = 8'h00;
    bus.in_vld    = 1'b0;
    bus.in_data   = 32'h0;
    bus.w_req_rdy = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_rdy", bus.in_rdy, 0);
    check("rst_w_req_vld", bus.w_req_vld, 0);
    check("rst_w_req_addr", bus.w_req_addr, 0);
    check("rst_w_req_data", bus.w_req_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //          base   shift  acc (elem3..elem0)                                 addr (3..0)
    tbl[0] = '{8'h40, 5'd0, {32'd300, 32'd3, 32'd2, 32'd1},
               {8'h43, 8'h42, 8'h41, 8'h40}, {8'hFF, 8'h03, 8'h02, 8'h01},
               32'h0, 1'b0, 1'b1};
    tbl[1] = '{8'h80, 5'd4, {32'h0FFF, 32'h08, 32'h18, 32'h17},
               {8'h83, 8'h82, 8'h81, 8'h80}, {8'hFF, 8'h01, 8'h02, 8'h01},
               32'h0, 1'b0, 1'b0};
    tbl[2] = '{8'h10, 5'd31, {32'h0, 32'h3FFFFFFF, 32'h40000000, 32'hFFFFFFFF},
               {8'h13, 8'h12, 8'h11, 8'h10}, {8'h00, 8'h00, 8'h01, 8'h02},
               32'h0, 1'b0, 1'b0};
    tbl[3] = '{8'hFE, 5'd0, {32'd40, 32'd30, 32'd20, 32'd10},
               {8'h01, 8'h00, 8'hFF, 8'hFE}, {8'd40, 8'd30, 8'd20, 8'd10},
               32'b0110_0110, 1'b0, 1'b0};
    tbl[4] = '{8'h20, 5'd1, {32'd7, 32'd6, 32'd5, 32'd4},
               {8'h23, 8'h22, 8'h21, 8'h20}, {8'h04, 8'h03, 8'h03, 8'h02},
               32'h0, 1'b1, 1'b0};

    for (int t = 0; t < 5; t++) begin
      run_vec($sformatf("vec%0d", t), 1'b1, tbl[t]);
    end

    // Stream valid while idle must not be accepted.
    clear_log();
    bus.in_vld  = 1'b1;
    bus.in_data = 32'h7;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check($sformatf("idle_in_rdy%0d", c), bus.in_rdy, 0);
    end
    bus.in_vld = 1'b0;
    check("idle_no_writes", wq_addr.size(), 0);
    check("idle_no_accepts", acc_cnt - acc_base, 0);

    // Reset in the middle of a vector.
    cfg(2'b00, 8'h40);
    cfg(2'b01, 8'h04);
    clear_log();
    cfg(2'b10, 8'h00);
    for (int c = 0; c < 40; c++) begin
      bus.in_vld  = ((acc_cnt - acc_base) < 4);
      bus.in_data = 32'h100 + 32'(acc_cnt - acc_base);
      @(posedge clk); #1;
      if (wq_addr.size() >= 2) break;
    end
    check("mid_rst_reached_two_writes", wq_addr.size() >= 2, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_rdy", bus.in_rdy, 0);
    check("mid_rst_w_req_vld", bus.w_req_vld, 0);
    check("mid_rst_w_req_addr", bus.w_req_addr, 0);
    check("mid_rst_w_req_data", bus.w_req_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    bus.in_vld = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Base and shift must be back at zero: data passes through unshifted from address 0.
    vrst = '{8'h00, 5'd0, {32'd300, 32'd7, 32'd6, 32'd5},
             {8'h03, 8'h02, 8'h01, 8'h00}, {8'hFF, 8'h07, 8'h06, 8'h05},
             32'h0, 1'b0, 1'b0};
    run_vec("post_rst", 1'b0, vrst);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
